// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM states,
// scoreboard entry layout and forwarding-select encodings.
package pipe_pkg;

  localparam logic [5:0] OP_ALU  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF     = 2'd0;
  localparam logic [1:0] FWD_EXEMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = datapath side (drives ID instruction and events), slave = controller.
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [31:0] ir_id;
  logic        br_taken_mem;
  logic        run;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idexe_bubble;
  logic        exemem_flush;
  state_t      state;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;

  modport master (
    output ir_id, br_taken_mem, run,
    input  pc_write, ifid_write, ifid_flush, idexe_bubble, exemem_flush,
           state, halted, stall_cnt, fwd_a, fwd_b
  );

  modport slave (
    input  ir_id, br_taken_mem, run,
    output pc_write, ifid_write, ifid_flush, idexe_bubble, exemem_flush,
           state, halted, stall_cnt, fwd_a, fwd_b
  );

endinterface

// File: rtl/pipe_dec.sv
// Purely combinational field decode of the ID-stage instruction:
// destination, source registers in use, load and halt flags.
module pipe_dec
  import pipe_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        use_rs,
  output logic        use_rt,
  output logic        has_dest,
  output logic [4:0]  dest,
  output logic        is_load,
  output logic        is_halt
);

  // Immediate/funct bits carry no register information for hazard purposes.
  logic unused_funct;
  assign unused_funct = ^ir[10:0];

  assign rs = ir[25:21];
  assign rt = ir[20:16];

  // Opcode to register-usage mapping; unknown opcodes touch no registers.
  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    has_dest = 1'b0;
    dest     = 5'd0;
    is_load  = 1'b0;
    is_halt  = 1'b0;
    case (ir[31:26])
      OP_ALU: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        has_dest = 1'b1;
        dest     = ir[15:11];
      end
      OP_LW: begin
        use_rs   = 1'b1;
        has_dest = 1'b1;
        dest     = ir[20:16];
        is_load  = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EXE/MEM/WB destination scoreboard, RAW stall
// detection, branch flush, HALT/run sequencing and a saturating stall counter.
// Build option PIPE_FWD_EN: enables operand forwarding selects and restricts
// stalls to load-use hazards.
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
);

  logic [4:0]  dec_rs, dec_rt, dec_dest;
  logic        dec_use_rs, dec_use_rt, dec_has_dest, dec_is_load, dec_is_halt;
  sb_entry_t   dec_entry;
  sb_entry_t   sb_exe, sb_mem, sb_wb;
  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q;
  logic        hazard, stall_cyc;
  logic        hit_rs_exe, hit_rt_exe, hit_rs_mem, hit_rt_mem;
  logic        pc_write, ifid_write, ifid_flush, idexe_bubble, exemem_flush;

  // WB is tracked so the pipeline picture is complete, but the register file
  // writes in the first half-cycle so it never causes a conflict.
  logic unused_sb;
  assign unused_sb = ^{sb_wb, sb_exe.is_load};

  function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                   input sb_entry_t e);
    return use_src && e.valid && (e.dest != 5'd0) && (e.dest == src);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  pipe_dec u_dec (
    .ir       (hz.ir_id),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .use_rs   (dec_use_rs),
    .use_rt   (dec_use_rt),
    .has_dest (dec_has_dest),
    .dest     (dec_dest),
    .is_load  (dec_is_load),
    .is_halt  (dec_is_halt)
  );

  assign dec_entry  = '{valid: dec_has_dest, dest: dec_dest, is_load: dec_is_load};
  assign hit_rs_exe = src_hit(dec_use_rs, dec_rs, sb_exe);
  assign hit_rt_exe = src_hit(dec_use_rt, dec_rt, sb_exe);
  assign hit_rs_mem = src_hit(dec_use_rs, dec_rs, sb_mem);
  assign hit_rt_mem = src_hit(dec_use_rt, dec_rt, sb_mem);

`ifdef PIPE_FWD_EN
  // Only a load still in EXE cannot be forwarded in time.
  assign hazard   = sb_exe.is_load && (hit_rs_exe || hit_rt_exe);
  assign hz.fwd_a = hit_rs_exe ? FWD_EXEMEM : (hit_rs_mem ? FWD_MEMWB : FWD_RF);
  assign hz.fwd_b = hit_rt_exe ? FWD_EXEMEM : (hit_rt_mem ? FWD_MEMWB : FWD_RF);
`else
  assign hazard   = hit_rs_exe || hit_rt_exe || hit_rs_mem || hit_rt_mem;
  assign hz.fwd_a = FWD_RF;
  assign hz.fwd_b = FWD_RF;
`endif

  // Only genuine hazard stalls count; flush wins over stall and HALT never counts.
  assign stall_cyc = (state_q != HALT) && !hz.br_taken_mem && hazard;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state: HALT waits for run; otherwise state records last cycle's action
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT: if (hz.run) state_d = RUN;
      default: begin
        if (hz.br_taken_mem)  state_d = FLUSH;
        else if (dec_is_halt) state_d = HALT;
        else if (hazard)      state_d = STALL;
        else                  state_d = RUN;
      end
    endcase
  end

  // FSM outputs: pipeline enables, bubbles and flushes for the current cycle
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    exemem_flush = 1'b0;
    if (state_q == HALT) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idexe_bubble = 1'b1;
      ifid_flush   = hz.run;
    end else if (hz.br_taken_mem) begin
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
      exemem_flush = 1'b1;
    end else if (hazard) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idexe_bubble = 1'b1;
    end
  end

  // Scoreboard shift; in HALT the ID word stays put and MEM/WB drain empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_exe <= SB_EMPTY;
      sb_mem <= SB_EMPTY;
      sb_wb  <= SB_EMPTY;
    end else if (state_q == HALT) begin
      sb_mem <= SB_EMPTY;
      sb_wb  <= sb_mem;
    end else begin
      sb_exe <= idexe_bubble ? SB_EMPTY : dec_entry;
      sb_mem <= exemem_flush ? SB_EMPTY : sb_exe;
      sb_wb  <= sb_mem;
    end
  end

  // Saturating count of hazard-stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stall_cnt_q <= 16'd0;
    else if (stall_cyc) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idexe_bubble = idexe_bubble;
  assign hz.exemem_flush = exemem_flush;
  assign hz.state        = state_q;
  assign hz.halted       = (state_q == HALT);
  assign hz.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default and PIPE_FWD_EN builds).
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idexe_bubble, exemem_flush}
  logic [4:0] ctl;
  assign ctl = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idexe_bubble, hz.exemem_flush};

  function automatic logic [31:0] alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000100, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] rs);
    return {6'b100000, rs, rt, 16'd0};
  endfunction

  localparam logic [31:0] HALT_W = {6'b111111, 26'd0};
  localparam logic [31:0] NOP_W  = 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hz.ir_id = NOP_W;
    hz.br_taken_mem = 1'b0;
    hz.run = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    hz.ir_id = NOP_W;
    hz.br_taken_mem = 1'b0;
    hz.run = 1'b0;
    rst_n = 1'b0;
    #2;
    if (ctl !== 5'b11000) begin $display("FAIL reset_ctl: got %b want 11000", ctl); n_fail++; end
    n_tests++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'd0) begin $display("FAIL reset_fwd: got %0d/%0d want 0/0", hz.fwd_a, hz.fwd_b); n_fail++; end
    n_tests++;
    if (hz.halted !== 1'b0) begin $display("FAIL reset_halted: got %b want 0", hz.halted); n_fail++; end
    n_tests++;
    if (hz.state !== 2'd0) begin $display("FAIL reset_state: got %0d want 0", hz.state); n_fail++; end
    n_tests++;
    if (hz.stall_cnt !== 16'd0) begin $display("FAIL reset_stall_cnt: got %0d want 0", hz.stall_cnt); n_fail++; end
    n_tests++;
  endtask

  // ALU r3 in EXE, ID reads r3
  task automatic test_raw();
    do_reset();
    hz.ir_id = alu(5'd3, 5'd1, 5'd2);
    #1;
    if (ctl !== 5'b11000) begin $display("FAIL raw_issue: got %b want 11000", ctl); n_fail++; end
    n_tests++;
    tick();
    hz.ir_id = alu(5'd4, 5'd3, 5'd0);
    #1;
`ifdef PIPE_FWD_EN
    if (ctl !== 5'b11000) begin $display("FAIL raw_fwd_nostall: got %b want 11000", ctl); n_fail++; end
    n_tests++;
    if (hz.fwd_a !== 2'd1 || hz.fwd_b !== 2'd0) begin $display("FAIL raw_fwd_exe: got a=%0d b=%0d want a=1 b=0", hz.fwd_a, hz.fwd_b); n_fail++; end
    n_tests++;
    tick();
    hz.ir_id = alu(5'd5, 5'd3, 5'd0);
    #1;
    if (hz.fwd_a !== 2'd2) begin $display("FAIL raw_fwd_mem: got %0d want 2", hz.fwd_a); n_fail++; end
    n_tests++;
    if (hz.stall_cnt !== 16'd0) begin $display("FAIL raw_fwd_cnt: got %0d want 0", hz.stall_cnt); n_fail++; end
    n_tests++;
`else
    if (ctl !== 5'b00010) begin $display("FAIL raw_stall1: got %b want 00010", ctl); n_fail++; end
    n_tests++;
    tick();
    #1;
    if (ctl !== 5'b00010) begin $display("FAIL raw_stall2: got %b want 00010", ctl); n_fail++; end
    n_tests++;
    if (hz.state !== 2'd1) begin $display("FAIL raw_state_stall: got %0d want 1", hz.state); n_fail++; end
    n_tests++;
    tick();
    #1;
    if (ctl !== 5'b11000) begin $display("FAIL raw_release: got %b want 11000", ctl); n_fail++; end
    n_tests++;
    if (hz.stall_cnt !== 16'd2) begin $display("FAIL raw_cnt: got %0d want 2", hz.stall_cnt); n_fail++; end
    n_tests++;
`endif
  endtask

  // LW r5 in EXE, ID reads r5
  task automatic test_load_use();
    do_reset();
    hz.ir_id = lw(5'd5, 5'd1);
    tick();
    hz.ir_id = alu(5'd6, 5'd5, 5'd0);
    #1;
    if (ctl !== 5'b00010) begin $display("FAIL lu_stall1: got %b want 00010", ctl); n_fail++; end
    n_tests++;
    tick();
    #1;
`ifdef PIPE_FWD_EN
    if (ctl !== 5'b11000) begin $display("FAIL lu_release: got %b want 11000", ctl); n_fail++; end
    n_tests++;
    if (hz.fwd_a !== 2'd2) begin $display("FAIL lu_fwd: got %0d want 2", hz.fwd_a); n_fail++; end
    n_tests++;
    if (hz.stall_cnt !== 16'd1) begin $display("FAIL lu_cnt: got %0d want 1", hz.stall_cnt); n_fail++; end
    n_tests++;
`else
    if (ctl !== 5'b00010) begin $display("FAIL lu_stall2: got %b want 00010", ctl); n_fail++; end
    n_tests++;
    tick();
    #1;
    if (ctl !== 5'b11000) begin $display("FAIL lu_release: got %b want 11000", ctl); n_fail++; end
    n_tests++;
    if (hz.stall_cnt !== 16'd2 || hz.fwd_a !== 2'd0) begin $display("FAIL lu_cnt: got cnt=%0d fwd=%0d want cnt=2 fwd=0", hz.stall_cnt, hz.fwd_a); n_fail++; end
    n_tests++;
`endif
  endtask

  // Taken branch in MEM coinciding with a load-use hazard
  task automatic test_flush_over_hazard();
    do_reset();
    hz.ir_id = lw(5'd3, 5'd1);
    tick();
    hz.ir_id = alu(5'd4, 5'd3, 5'd0);
    hz.br_taken_mem = 1'b1;
    #1;
    if ({hz.pc_write, hz.ifid_flush, hz.idexe_bubble, hz.exemem_flush} !== 4'b1111) begin
      $display("FAIL flush_ctl: got %b want pc/ifid_flush/bubble/exemem_flush=1111", ctl); n_fail++;
    end
    n_tests++;
    tick();
    hz.br_taken_mem = 1'b0;
    hz.ir_id = NOP_W;
    #1;
    if (hz.state !== 2'd2) begin $display("FAIL flush_state: got %0d want 2", hz.state); n_fail++; end
    n_tests++;
    if (hz.stall_cnt !== 16'd0) begin $display("FAIL flush_cnt: got %0d want 0", hz.stall_cnt); n_fail++; end
    n_tests++;
    if (ctl !== 5'b11000) begin $display("FAIL flush_after: got %b want 11000", ctl); n_fail++; end
    n_tests++;
  endtask

  // HALT in ID, drain, then run
  task automatic test_halt();
    do_reset();
    hz.ir_id = alu(5'd7, 5'd1, 5'd2);
    tick();
    hz.ir_id = HALT_W;
    #1;
    if (hz.halted !== 1'b0 || hz.state !== 2'd0) begin $display("FAIL halt_pre: got halted=%b state=%0d want 0/0", hz.halted, hz.state); n_fail++; end
    n_tests++;
    tick();
    #1;
    if (hz.halted !== 1'b1 || hz.state !== 2'd3) begin $display("FAIL halt_enter: got halted=%b state=%0d want 1/3", hz.halted, hz.state); n_fail++; end
    n_tests++;
    if (ctl !== 5'b00010) begin $display("FAIL halt_ctl: got %b want 00010", ctl); n_fail++; end
    n_tests++;
    tick();
    #1;
    if (hz.halted !== 1'b1) begin $display("FAIL halt_hold: got %b want 1", hz.halted); n_fail++; end
    n_tests++;
    tick();
    hz.run = 1'b1;
    #1;
    if (hz.ifid_flush !== 1'b1 || hz.halted !== 1'b1) begin $display("FAIL halt_run_pulse: got flush=%b halted=%b want 1/1", hz.ifid_flush, hz.halted); n_fail++; end
    n_tests++;
    tick();
    hz.run = 1'b0;
    hz.ir_id = alu(5'd8, 5'd7, 5'd7);
    #1;
    if (hz.state !== 2'd0 || hz.halted !== 1'b0) begin $display("FAIL halt_exit: got state=%0d halted=%b want 0/0", hz.state, hz.halted); n_fail++; end
    n_tests++;
    if (ctl !== 5'b11000 || hz.fwd_a !== 2'd0) begin $display("FAIL halt_sb_empty: got ctl=%b fwd_a=%0d want 11000/0", ctl, hz.fwd_a); n_fail++; end
    n_tests++;
    if (hz.stall_cnt !== 16'd0) begin $display("FAIL halt_cnt: got %0d want 0", hz.stall_cnt); n_fail++; end
    n_tests++;
  endtask

  // Build stall_cnt to 7, enter HALT, then assert reset between clock edges
  task automatic test_reset_mid_halt();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      hz.ir_id = lw(5'd5, 5'd1);
      tick();
`ifndef PIPE_FWD_EN
      hz.ir_id = NOP_W;
      tick();
`endif
      hz.ir_id = alu(5'd6, 5'd5, 5'd0);
      tick();
      tick();
    end
    if (hz.stall_cnt !== 16'd7) begin $display("FAIL rst_pre_cnt: got %0d want 7", hz.stall_cnt); n_fail++; end
    n_tests++;
    hz.ir_id = HALT_W;
    tick();
    #1;
    if (hz.halted !== 1'b1) begin $display("FAIL rst_pre_halt: got %b want 1", hz.halted); n_fail++; end
    n_tests++;
    #3;
    rst_n = 1'b0;
    #1;
    if (hz.state !== 2'd0 || hz.halted !== 1'b0) begin $display("FAIL rst_async_state: got state=%0d halted=%b want 0/0", hz.state, hz.halted); n_fail++; end
    n_tests++;
    if (hz.stall_cnt !== 16'd0) begin $display("FAIL rst_async_cnt: got %0d want 0", hz.stall_cnt); n_fail++; end
    n_tests++;
    if (ctl !== 5'b11000) begin $display("FAIL rst_async_ctl: got %b want 11000", ctl); n_fail++; end
    n_tests++;
    hz.ir_id = NOP_W;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    if (hz.state !== 2'd0 || ctl !== 5'b11000) begin $display("FAIL rst_resume: got state=%0d ctl=%b want 0/11000", hz.state, ctl); n_fail++; end
    n_tests++;
  endtask

  initial begin
    test_reset();
    test_raw();
    test_load_use();
    test_flush_over_hazard();
    test_halt();
    test_reset_mid_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock for all state; every register updates on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ir_id  input  32  instruction currently in the ID stage.
REQ-004 SHALL have port: br_taken_mem  input  1  a branch in MEM resolved taken this cycle.
REQ-005 SHALL have port: run  input  1  single-cycle pulse that leaves HALT.
REQ-006 SHALL have ports: pc_write, ifid_write  output  1 each  enables for the PC and IF/ID registers.
REQ-007 SHALL have ports: ifid_flush, idexe_bubble, exemem_flush  output  1 each  zero IR into IF/ID, ID/EXE and EXE/MEM respectively.
REQ-008 SHALL have ports: state  output  2  current FSM state; halted  output  1  (state==HALT).
REQ-009 SHALL have port: stall_cnt  output  16  count of stall cycles.
REQ-010 SHALL have ports: fwd_a, fwd_b  output  2 each  ALU operand source: 0=regfile, 1=EXE/MEM, 2=MEM/WB.

Function
REQ-011 SHALL decode ir_id[31:26]:
  - ALU 000100: dest rd=[15:11]; sources rs=[25:21], rt=[20:16].
  - LW 100000: dest rt; source rs.
  - SW 000010: sources rs, rt; no dest.
  - BEQ 000110: sources rs, rt; no dest.
  - HALT 111111: no dest, no sources.
  - Any other opcode: no dest, no sources.
REQ-012 SHALL keep a 3-entry scoreboard {valid, dest[4:0], is_load} for EXE, MEM and WB, shifting every cycle unless in HALT.
  - EXE takes the decode of ir_id, or invalid when idexe_bubble.
  - MEM takes EXE, or invalid when exemem_flush.
  - WB takes MEM.
REQ-013 SHALL treat dest 0 as never conflicting.
REQ-014 SHALL flag a hazard when an ID source equals the valid dest of the EXE or MEM entry. The WB entry never conflicts, because the register file writes in the first half-cycle.
REQ-015 SHALL, on hazard, in the same cycle: pc_write=0, ifid_write=0, idexe_bubble=1.
REQ-016 SHALL, on br_taken_mem, in the same cycle: ifid_flush=1, idexe_bubble=1, exemem_flush=1, pc_write=1. Flush overrides hazard stall.
REQ-017 SHALL implement FSM states RUN=0, STALL=1, FLUSH=2, HALT=3.
  - STALL means the previous cycle stalled; FLUSH means the previous cycle flushed.
  - RUN, STALL and FLUSH each go to FLUSH if br_taken_mem, else to HALT if ir_id is HALT, else to STALL if hazard, else to RUN.
REQ-018 SHALL, in HALT, hold pc_write=0, ifid_write=0, idexe_bubble=1 and freeze the scoreboard shift, except that MEM and WB drain to invalid.
REQ-019 SHALL, on run in HALT, go to RUN and assert ifid_flush for that one cycle to discard the HALT word. run is ignored in other states.
REQ-020 SHALL increment stall_cnt once per hazard-stall cycle, saturating at 16'hFFFF. HALT cycles and flush cycles SHALL NOT count.
REQ-021 SHALL set a bubble- or flush-inserted entry to valid=0.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force: state=RUN, all scoreboard entries invalid, stall_cnt=0.
REQ-023 SHALL produce these outputs under reset: pc_write=1, ifid_write=1, all flush/bubble=0, fwd_a=fwd_b=0, halted=0.
REQ-024 SHALL, when reset asserts mid-stall or mid-HALT, abandon that stall or HALT immediately and resume in RUN on the first edge after release.

Configuration
REQ-025 SHALL support macro PIPE_FWD_EN.
  - Defined: fwd_a/fwd_b select EXE/MEM (1) on an EXE dest match, else MEM/WB (2) on a MEM dest match. EXE takes priority.
  - Defined: a hazard is raised only when the EXE entry is_load matches (load-use).
  - Undefined: fwd_a=fwd_b=0 constantly, and REQ-014 applies.

Structure
REQ-026 SHALL place these in shared package pipe_pkg, together with the fwd select encodings:
  - opcode constants OP_ALU, OP_LW, OP_SW, OP_BEQ, OP_HALT;
  - state enum RUN/STALL/FLUSH/HALT;
  - scoreboard entry typedef.
REQ-027 SHALL isolate instruction field decode (dest, sources, is_load, is_halt) in sub-module pipe_dec, purely combinational.

Verification
REQ-028 SHALL test: ALU r3 in EXE, ID = ALU reading r3, no PIPE_FWD_EN -> 2 stall cycles, stall_cnt=2, idexe_bubble high both cycles.
REQ-029 SHALL test: same as REQ-028 with PIPE_FWD_EN -> no stall, fwd_a=1; next cycle, a dependent instruction gets fwd_a=2.
REQ-030 SHALL test: LW r5 in EXE, ID reads r5, PIPE_FWD_EN -> exactly 1 stall, then fwd=2.
REQ-031 SHALL test: br_taken_mem=1 coinciding with a hazard -> flushes asserted, pc_write=1, state=FLUSH next cycle, stall_cnt unchanged.
REQ-032 SHALL test: HALT in ID -> halted=1 until run; after 2 cycles the scoreboard is empty; run -> ifid_flush pulse, then state=RUN.
REQ-033 SHALL test: rst_n low during HALT with stall_cnt=7 -> state=RUN and stall_cnt=0 immediately, without a clock edge.
